// File: rtl/step_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : step_counter_pkg
// Description : Shared mode encodings, default parameters and clamp helper
//               for the step counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
package step_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int DEF_CH            = 4;
    localparam int DEF_W             = 16;
    localparam int DEF_STEP_W        = 11;
    localparam int DEF_DEFAULT_VALUE = 1;

    // Operands are carried at 32 bits so the helper serves any W up to 32.
    function automatic logic [31:0] clamp(input logic [31:0] val,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        if (val < lo)
            return lo;
        else if (val > hi)
            return hi;
        else
            return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_counter_chan.sv
`default_nettype none
// ============================================================================
// Module      : step_counter_chan
// Description : One up/down step counter with programmable step, limit,
//               wrap/saturate mode, load and registered event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module step_counter_chan
    import step_counter_pkg::*;
#(
    parameter int W             = DEF_W,
    parameter int STEP_W        = DEF_STEP_W,
    parameter int DEFAULT_VALUE = DEF_DEFAULT_VALUE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic [W-1:0]      limit,
    input  logic              mode,
    input  logic              load,
    input  logic [W-1:0]      load_val,
    output logic [W-1:0]      count,
    output logic              changed,
    output logic              wrapped,
    output logic              sat_hit
);

    localparam logic [W-1:0] c_def = W'(DEFAULT_VALUE);

    logic [W-1:0] r_count;
    logic         r_changed;
    logic         r_wrapped;
    logic         r_sat_hit;

    logic [W:0]   w_eff_step;
    logic [W-1:0] w_eff_lim;
    logic [W:0]   w_sum;
    logic [W:0]   w_floor;
    logic [W-1:0] w_count_nxt;
    logic         w_changed_nxt;
    logic         w_wrapped_nxt;
    logic         w_sat_hit_nxt;

    // Sum and floor are kept one bit wider so top-of-range steps compare correctly.
    assign w_eff_step = (step == '0) ? (W+1)'(1) : (W+1)'(step);
    assign w_eff_lim  = (limit < c_def) ? c_def : limit;
    assign w_sum      = {1'b0, r_count} + w_eff_step;
    assign w_floor    = {1'b0, c_def} + w_eff_step;

    always_comb begin
        w_count_nxt   = r_count;
        w_changed_nxt = 1'b0;
        w_wrapped_nxt = 1'b0;
        w_sat_hit_nxt = 1'b0;
        if (load) begin
            w_count_nxt   = W'(clamp(32'(load_val), 32'(c_def), 32'(w_eff_lim)));
            w_changed_nxt = 1'b1;
        end else if (inc && !dec) begin
            w_changed_nxt = 1'b1;
            if (w_sum <= {1'b0, w_eff_lim}) begin
                w_count_nxt = w_sum[W-1:0];
            end else if (mode == MODE_SAT) begin
                w_count_nxt   = w_eff_lim;
                w_sat_hit_nxt = 1'b1;
            end else begin
                w_count_nxt   = c_def;
                w_wrapped_nxt = 1'b1;
            end
        end else if (dec && !inc) begin
            w_changed_nxt = 1'b1;
            if ({1'b0, r_count} >= w_floor) begin
                w_count_nxt = r_count - w_eff_step[W-1:0];
            end else if (mode == MODE_SAT) begin
                w_count_nxt   = c_def;
                w_sat_hit_nxt = 1'b1;
            end else begin
                w_count_nxt   = w_eff_lim;
                w_wrapped_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= c_def;
            r_changed <= 1'b0;
            r_wrapped <= 1'b0;
            r_sat_hit <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_changed <= w_changed_nxt;
            r_wrapped <= w_wrapped_nxt;
            r_sat_hit <= w_sat_hit_nxt;
        end
    end

    assign count   = r_count;
    assign changed = r_changed;
    assign wrapped = r_wrapped;
    assign sat_hit = r_sat_hit;

endmodule
`default_nettype wire

// File: rtl/step_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : step_counter_bank
// Description : Bank of CH independent step counters on flat input/output
//               buses; channel i occupies slice i of every bus.
// Revision    : 1.0 - initial release
// ============================================================================
module step_counter_bank
    import step_counter_pkg::*;
#(
    parameter int CH            = DEF_CH,
    parameter int W             = DEF_W,
    parameter int STEP_W        = DEF_STEP_W,
    parameter int DEFAULT_VALUE = DEF_DEFAULT_VALUE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        inc,
    input  logic [CH-1:0]        dec,
    input  logic [CH*STEP_W-1:0] step,
    input  logic [CH*W-1:0]      limit,
    input  logic [CH-1:0]        mode,
    input  logic [CH-1:0]        load,
    input  logic [CH*W-1:0]      load_val,
    output logic [CH*W-1:0]      count,
    output logic [CH-1:0]        changed,
    output logic [CH-1:0]        wrapped,
    output logic [CH-1:0]        sat_hit
);

    for (genvar g = 0; g < CH; g++) begin : g_chan
        step_counter_chan #(
            .W            (W),
            .STEP_W       (STEP_W),
            .DEFAULT_VALUE(DEFAULT_VALUE)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc[g]),
            .dec     (dec[g]),
            .step    (step[g*STEP_W +: STEP_W]),
            .limit   (limit[g*W +: W]),
            .mode    (mode[g]),
            .load    (load[g]),
            .load_val(load_val[g*W +: W]),
            .count   (count[g*W +: W]),
            .changed (changed[g]),
            .wrapped (wrapped[g]),
            .sat_hit (sat_hit[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_step_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_counter_bank
// Description : Directed and randomized checks of step_counter_bank against
//               an integer reference model of each channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_counter_bank;

    localparam int CH     = 4;
    localparam int W      = 16;
    localparam int STEP_W = 11;
    localparam int DEF    = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [CH-1:0]        inc, dec, mode, load;
    logic [CH*STEP_W-1:0] step;
    logic [CH*W-1:0]      limit, load_val;
    logic [CH*W-1:0]      count;
    logic [CH-1:0]        changed, wrapped, sat_hit;

    int  m_count [CH];
    bit  m_chg   [CH];
    bit  m_wr    [CH];
    bit  m_sat   [CH];
    int  total = 0;
    int  bad   = 0;

    step_counter_bank #(.CH(CH), .W(W), .STEP_W(STEP_W), .DEFAULT_VALUE(DEF)) dut (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .step(step), .limit(limit),
        .mode(mode), .load(load), .load_val(load_val), .count(count),
        .changed(changed), .wrapped(wrapped), .sat_hit(sat_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int c);
        return int'(count[c*W +: W]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_count[c] = DEF;
            m_chg[c] = 0; m_wr[c] = 0; m_sat[c] = 0;
        end
    endtask

    // Counts are plain integers here: overflow past 2^W cannot hide.
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < CH; c++) begin
            int st, lim, lv, s;
            st  = int'(step[c*STEP_W +: STEP_W]);
            lim = int'(limit[c*W +: W]);
            lv  = int'(load_val[c*W +: W]);
            if (st == 0) st = 1;
            if (lim < DEF) lim = DEF;
            m_chg[c] = 0; m_wr[c] = 0; m_sat[c] = 0;
            if (load[c]) begin
                m_count[c] = (lv < DEF) ? DEF : (lv > lim) ? lim : lv;
                m_chg[c] = 1;
            end else if (inc[c] && !dec[c]) begin
                m_chg[c] = 1;
                s = m_count[c] + st;
                if (s <= lim)          m_count[c] = s;
                else if (mode[c] == 0) begin m_count[c] = DEF; m_wr[c] = 1; end
                else                   begin m_count[c] = lim; m_sat[c] = 1; end
            end else if (dec[c] && !inc[c]) begin
                m_chg[c] = 1;
                s = m_count[c] - st;
                if (s >= DEF)          m_count[c] = s;
                else if (mode[c] == 0) begin m_count[c] = lim; m_wr[c] = 1; end
                else                   begin m_count[c] = DEF; m_sat[c] = 1; end
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < CH; c++) begin
            check($sformatf("count%0d", c),   32'(cnt_of(c)), 32'(m_count[c]));
            check($sformatf("changed%0d", c), 32'(changed[c]), 32'(m_chg[c]));
            check($sformatf("wrapped%0d", c), 32'(wrapped[c]), 32'(m_wr[c]));
            check($sformatf("sat_hit%0d", c), 32'(sat_hit[c]), 32'(m_sat[c]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic clear_strobes();
        inc = '0; dec = '0; load = '0;
    endtask

    task automatic set_ch(input int c, input bit i, input bit d, input int st,
                          input int lim, input bit md, input bit ld, input int lv);
        inc[c] = i; dec[c] = d; mode[c] = md; load[c] = ld;
        step[c*STEP_W +: STEP_W] = STEP_W'(st);
        limit[c*W +: W]          = W'(lim);
        load_val[c*W +: W]       = W'(lv);
    endtask

    // Asserted half-way between edges; outputs must follow without a clock.
    task automatic async_reset();
        #3 rst = 1'b1;
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        int exp_up [4];
        int exp_sat[7];
        rst = 1'b1;
        clear_strobes();
        mode = '0; step = '0; limit = '0; load_val = '0;
        model_reset();
        #3;
        check_all();
        repeat (2) cycle();
        rst = 1'b0;

        // 1: reset mid-count
        set_ch(0, 0, 0, 1, 100, 0, 1, 7);
        cycle();
        check("t1_load7", 32'(cnt_of(0)), 32'd7);
        clear_strobes();
        async_reset();
        check("t1_async", 32'(cnt_of(0)), 32'd1);
        cycle();
        rst = 1'b0;

        // 2: wrap up
        exp_up = '{4, 7, 10, 1};
        set_ch(0, 1, 0, 3, 10, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check($sformatf("t2_cnt%0d", k), 32'(cnt_of(0)), 32'(exp_up[k]));
            check($sformatf("t2_chg%0d", k), 32'(changed[0]), 32'd1);
        end
        check("t2_wrapped", 32'(wrapped[0]), 32'd1);
        clear_strobes();

        // 3: saturate at both ends
        exp_sat = '{5, 9, 10, 10, 6, 2, 1};
        set_ch(1, 1, 0, 4, 10, 1, 0, 0);
        for (int k = 0; k < 7; k++) begin
            if (k == 4) set_ch(1, 0, 1, 4, 10, 1, 0, 0);
            cycle();
            check($sformatf("t3_cnt%0d", k), 32'(cnt_of(1)), 32'(exp_sat[k]));
            if (k == 2 || k == 3 || k == 6)
                check($sformatf("t3_sat%0d", k), 32'(sat_hit[1]), 32'd1);
        end
        clear_strobes();

        // 4: wrap down with step 0
        set_ch(2, 0, 1, 0, 20, 0, 0, 0);
        cycle();
        check("t4_wrapcnt", 32'(cnt_of(2)), 32'd20);
        check("t4_wrapped", 32'(wrapped[2]), 32'd1);
        cycle();
        check("t4_step0", 32'(cnt_of(2)), 32'd19);
        clear_strobes();

        // 5: load wins over simultaneous inc/dec, then inc+dec holds
        set_ch(3, 0, 0, 1, 30, 0, 1, 5);
        cycle();
        set_ch(3, 1, 1, 1, 30, 0, 1, 50);
        cycle();
        check("t5_loadclamp", 32'(cnt_of(3)), 32'd30);
        check("t5_chg", 32'(changed[3]), 32'd1);
        set_ch(3, 1, 1, 1, 30, 0, 0, 50);
        cycle();
        check("t5_hold", 32'(cnt_of(3)), 32'd30);
        check("t5_nochg", 32'(changed[3]), 32'd0);
        clear_strobes();

        // 6: full-width independence
        set_ch(0, 0, 0, 2047, 65535, 0, 1, 65000);
        set_ch(1, 0, 0, 100, 5000, 1, 1, 3000);
        cycle();
        set_ch(0, 1, 0, 2047, 65535, 0, 0, 0);
        set_ch(1, 0, 1, 100, 5000, 1, 0, 0);
        cycle();
        check("t6_ch0wrap", 32'(cnt_of(0)), 32'd1);
        check("t6_ch0wr", 32'(wrapped[0]), 32'd1);
        check("t6_ch1", 32'(cnt_of(1)), 32'd2900);
        set_ch(0, 0, 0, 2047, 65535, 1, 1, 65535);
        clear_strobes();
        load[0] = 1'b1;
        cycle();
        set_ch(0, 1, 0, 2047, 65535, 1, 0, 0);
        cycle();
        check("t6_ch0sat", 32'(cnt_of(0)), 32'd65535);
        check("t6_ch0sathit", 32'(sat_hit[0]), 32'd1);
        clear_strobes();

        // Randomized traffic on all channels
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < CH; c++) begin
                int st, lim;
                st  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 2047));
                lim = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40))
                                                  : int'($urandom_range(0, 65535));
                set_ch(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), st, lim,
                       1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                       int'($urandom_range(0, 65535)));
            end
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
                #2 rst = 1'b0;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
